// File: rtl/riscv_core_pkg.sv
// Shared definitions for the riscv_core select/pipeline blocks.
//  XLEN_DEFAULT : default datapath width
//  xlen_t       : one XLEN_DEFAULT-wide data word
//  sel_mode_e   : how a select vector is interpreted (binary index or one-hot)
//  sel_width()  : select-vector width for a given input count and select mode
package riscv_core_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef logic [XLEN_DEFAULT-1:0] xlen_t;

    typedef enum logic {
        SEL_BINARY = 1'b0,
        SEL_ONEHOT = 1'b1
    } sel_mode_e;

    function automatic int sel_width(input int num_in, input sel_mode_e mode);
        return (mode == SEL_ONEHOT) ? num_in : $clog2(num_in);
    endfunction

endpackage

// File: rtl/riscv_core_muxnx1_pipe_if.sv
// Valid/ready bundle for riscv_core_muxnx1_pipe.
//  upstream  : i_flush, i_data (NUM_IN packed words), i_sel, i_valid -> o_ready
//  downstream: o_data, o_err, o_valid -> i_ready
//  master modport drives the inputs and the downstream ready (the environment);
//  slave modport is the selector itself.
interface riscv_core_muxnx1_pipe_if #(
    parameter int XLEN   = riscv_core_pkg::XLEN_DEFAULT,
    parameter int NUM_IN = 4,
    parameter int ONEHOT = 0
);
    localparam int SEL_W = riscv_core_pkg::sel_width(
        NUM_IN, (ONEHOT != 0) ? riscv_core_pkg::SEL_ONEHOT : riscv_core_pkg::SEL_BINARY);

    logic                     i_flush;
    logic [NUM_IN*XLEN-1:0]   i_data;
    logic [SEL_W-1:0]         i_sel;
    logic                     i_valid;
    logic                     o_ready;
    logic [XLEN-1:0]          o_data;
    logic                     o_err;
    logic                     o_valid;
    logic                     i_ready;

    modport master (
        output i_flush, i_data, i_sel, i_valid, i_ready,
        input  o_ready, o_data, o_err, o_valid
    );

    modport slave (
        input  i_flush, i_data, i_sel, i_valid, i_ready,
        output o_ready, o_data, o_err, o_valid
    );

endinterface

// File: rtl/riscv_core_skid_buf.sv
// Two-entry elastic register stage (main + skid) with valid/ready handshake.
//  clk, rst   : clock, asynchronous active-high reset
//  flush      : synchronous; empties both entries, drops a same-cycle input
//  in_data/in_valid/in_ready    : upstream side; in_ready is a pure register output
//  out_data/out_valid/out_ready : downstream side, driven straight from main entry
module riscv_core_skid_buf #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] main_data_p1;
    logic [WIDTH-1:0] skid_data_p1;
    logic             main_vld_p1;
    logic             skid_vld_p1;
    logic             accept;
    logic             to_skid;

    // Ready depends only on skid occupancy, so there is no combinational path
    // from out_ready back to in_ready.
    assign in_ready = !skid_vld_p1;
    assign accept   = in_valid && in_ready;
    // Park the new entry only when main is occupied and cannot drain this cycle.
    assign to_skid  = accept && main_vld_p1 && !out_ready;

    // ---- stage p1: main / skid registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_p1  <= 1'b0;
            skid_vld_p1  <= 1'b0;
            main_data_p1 <= '0;
        end else if (flush) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (skid_vld_p1) begin
            // Upstream is stalled while skid is full; the skid entry moves up
            // as soon as main drains, which keeps strict FIFO order.
            if (out_ready) begin
                main_data_p1 <= skid_data_p1;
                skid_vld_p1  <= 1'b0;
            end
        end else if (accept) begin
            if (to_skid) begin
                skid_vld_p1 <= 1'b1;
            end else begin
                main_data_p1 <= in_data;
                main_vld_p1  <= 1'b1;
            end
        end else if (out_ready) begin
            main_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (to_skid && !flush) begin
            skid_data_p1 <= in_data;
        end
    end

    assign out_data  = main_data_p1;
    assign out_valid = main_vld_p1;

endmodule

// File: rtl/riscv_core_muxnx1_pipe.sv
// N-input, XLEN-wide selector with a registered elastic output stage.
//  i_clk, i_rst : clock, asynchronous active-high reset
//  bus (slave)  : i_flush, i_data, i_sel, i_valid, o_ready (upstream)
//                 o_data, o_err, o_valid, i_ready (downstream)
//  Binary select (ONEHOT=0) is legal when i_sel < NUM_IN; one-hot select
//  (ONEHOT=1) is legal when exactly one bit is set. An illegal select yields
//  data 0 with o_err=1. One cycle latency, one transfer per cycle.
module riscv_core_muxnx1_pipe
    import riscv_core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NUM_IN = 4,
    parameter int ONEHOT = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    riscv_core_muxnx1_pipe_if.slave   bus
);

    localparam sel_mode_e MODE  = (ONEHOT != 0) ? SEL_ONEHOT : SEL_BINARY;
    localparam int        SEL_W = sel_width(NUM_IN, MODE);

    logic [XLEN-1:0] dec_data_p0;
    logic            dec_err_p0;
    logic [XLEN:0]   out_word_p1;

    // ---- stage p0: select decode and legality check ----
    // Decode is purely combinational; its result is only captured when the
    // input handshake fires. Defaults give the illegal-select result, so an
    // unknown select can only ever produce {err=1, data=0}.
    if (MODE == SEL_ONEHOT) begin : g_onehot
        always_comb begin
            dec_data_p0 = '0;
            dec_err_p0  = 1'b1;
            if ($onehot(bus.i_sel)) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    if (bus.i_sel[k]) begin
                        dec_data_p0 = bus.i_data[k*XLEN +: XLEN];
                        dec_err_p0  = 1'b0;
                    end
                end
            end
        end
    end else begin : g_binary
        always_comb begin
            dec_data_p0 = '0;
            dec_err_p0  = 1'b1;
            for (int k = 0; k < NUM_IN; k++) begin
                if (bus.i_sel == SEL_W'(k)) begin
                    dec_data_p0 = bus.i_data[k*XLEN +: XLEN];
                    dec_err_p0  = 1'b0;
                end
            end
        end
    end

    // ---- stage p1: elastic register stage carrying {err, data} ----
    riscv_core_skid_buf #(
        .WIDTH (XLEN + 1)
    ) u_skid (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (bus.i_flush),
        .in_data   ({dec_err_p0, dec_data_p0}),
        .in_valid  (bus.i_valid),
        .in_ready  (bus.o_ready),
        .out_data  (out_word_p1),
        .out_valid (bus.o_valid),
        .out_ready (bus.i_ready)
    );

    assign bus.o_err  = out_word_p1[XLEN];
    assign bus.o_data = out_word_p1[XLEN-1:0];

endmodule

// File: tb/tb_riscv_core_muxnx1_pipe.sv
`timescale 1ns/1ps
module tb_riscv_core_muxnx1_pipe;
    import riscv_core_pkg::*;

    localparam int XW = XLEN_DEFAULT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic auto_mode = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Directed stimulus, applied to instance 0 while auto_mode is low.
    logic [4*XW-1:0] dir_data  = '0;
    logic [1:0]      dir_sel   = '0;
    logic            dir_valid = 1'b0;
    logic            dir_ready = 1'b1;
    logic            dir_flush = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [XW:0] act, input logic [XW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instance 0: 4 inputs binary; 1: 5 inputs binary; 2: 4 inputs one-hot.
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int NI = (g == 1) ? 5 : 4;
        localparam int OH = (g == 2) ? 1 : 0;
        localparam int SW = (OH != 0) ? NI : $clog2(NI);

        riscv_core_muxnx1_pipe_if #(.XLEN(XW), .NUM_IN(NI), .ONEHOT(OH)) bus ();

        riscv_core_muxnx1_pipe #(.XLEN(XW), .NUM_IN(NI), .ONEHOT(OH)) dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (bus)
        );

        logic [NI*XW-1:0] r_data  = '0;
        logic [SW-1:0]    r_sel   = '0;
        logic             r_valid = 1'b0;
        logic             r_ready = 1'b1;
        logic             r_flush = 1'b0;
        logic [XW:0]      q[$];

        always @(posedge clk) begin
            #1;
            r_valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NI; k++) r_data[k*XW +: XW] = {$urandom, $urandom};
            if (OH != 0 && $urandom_range(0, 1) == 1) r_sel = SW'(1) << $urandom_range(0, SW - 1);
            else r_sel = SW'($urandom);
            r_ready = ($urandom_range(0, 7) < 5);
            r_flush = ($urandom_range(0, 40) == 0);
        end

        if (g == 0) begin : g_drv
            assign bus.i_data  = auto_mode ? r_data  : dir_data;
            assign bus.i_sel   = auto_mode ? r_sel   : dir_sel;
            assign bus.i_valid = auto_mode ? r_valid : dir_valid;
            assign bus.i_ready = auto_mode ? r_ready : dir_ready;
            assign bus.i_flush = auto_mode ? r_flush : dir_flush;
        end else begin : g_drv
            assign bus.i_data  = r_data;
            assign bus.i_sel   = r_sel;
            assign bus.i_valid = auto_mode & r_valid;
            assign bus.i_ready = auto_mode ? r_ready : 1'b1;
            assign bus.i_flush = auto_mode & r_flush;
        end

        // Reference: selected word or {err=1, data=0} for an illegal select.
        function automatic logic [XW:0] model(input logic [NI*XW-1:0] d, input logic [SW-1:0] s);
            int idx;
            idx = -1;
            if (OH != 0) begin
                if ($countones(s) == 1)
                    for (int k = 0; k < SW; k++) if (s[k]) idx = k;
            end else if (int'(s) < NI) begin
                idx = int'(s);
            end
            if (idx < 0) return {1'b1, {XW{1'b0}}};
            return {1'b0, d[idx*XW +: XW]};
        endfunction

        // Stimulus side: record every accepted entry (or drop all on flush).
        always @(negedge clk) begin
            #2;
            if (rst || bus.i_flush) q.delete();
            else if (bus.i_valid && bus.o_ready) q.push_back(model(bus.i_data, bus.i_sel));
        end

        // Monitor: outputs must match a depth-2 FIFO of accepted entries.
        always @(negedge clk) begin
            if (!rst) begin
                chk($sformatf("dut%0d o_valid", g), (XW+1)'(bus.o_valid), (XW+1)'(q.size() > 0));
                chk($sformatf("dut%0d o_ready", g), (XW+1)'(bus.o_ready), (XW+1)'(q.size() < 2));
                if (bus.o_valid && q.size() > 0) begin
                    chk($sformatf("dut%0d {o_err,o_data}", g), {bus.o_err, bus.o_data}, q[0]);
                    if (bus.i_ready) void'(q.pop_front());
                end
            end
        end

        always @(posedge rst) begin
            #1;
            chk($sformatf("dut%0d reset o_valid", g), (XW+1)'(bus.o_valid), '0);
            chk($sformatf("dut%0d reset {o_err,o_data}", g), {bus.o_err, bus.o_data}, '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        step();

        // Plain selection, full throughput.
        dir_data  = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        dir_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            dir_valid = 1'b1;
            dir_sel   = 2'(s);
            step();
        end
        dir_valid = 1'b0;
        repeat (2) step();

        // Backpressure: A, B, C with downstream stalled for 3 cycles.
        dir_sel = 2'd0;
        dir_ready = 1'b0;
        dir_valid = 1'b1;
        dir_data[XW-1:0] = 64'h0000_0000_0000_000A; step();
        dir_data[XW-1:0] = 64'h0000_0000_0000_000B; step();
        dir_data[XW-1:0] = 64'h0000_0000_0000_000C; step();
        dir_ready = 1'b1;
        step();
        step();
        dir_valid = 1'b0;
        repeat (3) step();

        // Flush with main and skid full and a pending input.
        dir_ready = 1'b0;
        dir_valid = 1'b1;
        dir_data[XW-1:0] = 64'hD; step();
        dir_data[XW-1:0] = 64'hE; step();
        dir_data[XW-1:0] = 64'hF; dir_flush = 1'b1; step();
        dir_flush = 1'b0; dir_valid = 1'b0; dir_ready = 1'b1;
        step();

        // Flush coinciding with an input handshake, then a normal transfer.
        dir_ready = 1'b0;
        dir_valid = 1'b1;
        dir_data[XW-1:0] = 64'h1111; step();
        dir_data[XW-1:0] = 64'h2222; dir_flush = 1'b1; step();
        dir_flush = 1'b0; dir_ready = 1'b1;
        dir_data[XW-1:0] = 64'h3333; step();
        dir_valid = 1'b0;
        repeat (3) step();

        // Randomized traffic on all instances, with an asynchronous reset mid-stream.
        auto_mode = 1'b1;
        repeat (1500) @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (1500) @(posedge clk);
        #1 auto_mode = 1'b0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
